// File: rtl/ws2812_stream_driver.sv
// rtl/ws2812_stream_driver.sv - WS2812/SK6812 NRZ driver fed by a valid/ready pixel stream
module ws2812_stream_driver #(
    parameter int NUM_LED      = 8,
    parameter int BITS_PER_LED = 24,
    parameter int T0H          = 35,
    parameter int T0L          = 80,
    parameter int T1H          = 70,
    parameter int T1L          = 60,
    parameter int RES          = 6000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [7:0]              brightness,
    input  logic [BITS_PER_LED-1:0] pix_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic                    led_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    underrun
);
    localparam int MAX_H  = (T0H > T1H) ? T0H : T1H;
    localparam int MAX_L  = (T0L > T1L) ? T0L : T1L;
    localparam int MAX_HL = (MAX_H > MAX_L) ? MAX_H : MAX_L;
    localparam int MAX_T  = (RES > MAX_HL) ? RES : MAX_HL;
    localparam int TW     = $clog2(MAX_T + 1);
    localparam int CW     = $clog2(NUM_LED + 1);
    localparam int BW     = $clog2(BITS_PER_LED);
    localparam int NBYTES = BITS_PER_LED / 8;
    localparam int MSB    = BITS_PER_LED - 1;

    // Timer reload values are period-1 so a phase lasts exactly its period
    localparam logic [TW-1:0] T0H_L = TW'(T0H - 1);
    localparam logic [TW-1:0] T0L_L = TW'(T0L - 1);
    localparam logic [TW-1:0] T1H_L = TW'(T1H - 1);
    localparam logic [TW-1:0] T1L_L = TW'(T1L - 1);
    localparam logic [TW-1:0] RES_L = TW'(RES - 1);
    localparam logic [CW-1:0] NUM_C = CW'(NUM_LED);
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_LED - 1);

    typedef enum logic [2:0] {IDLE, FETCH, HIGH, LOW, LATCH} state_t;

    state_t                  state, state_nx;
    logic [TW-1:0]           timer, timer_nx;
    logic [BW-1:0]           bit_cnt, bit_cnt_nx;
    logic [BITS_PER_LED-1:0] shift, shift_nx;
    logic [BITS_PER_LED-1:0] pix_buf;
    logic [BITS_PER_LED-1:0] scaled;
    logic                    buf_full;
    logic [CW-1:0]           requested, sent, sent_nx, sent_inc;
    logic [7:0]              bright;
    logic                    xfer, load_buf, done_nx, underrun_set, accept;

    function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] s);
        logic [15:0] prod;
        prod = {8'h00, b} * ({8'h00, s} + 16'd1);
        return prod[15:8];
    endfunction

    always_comb begin
        scaled = '0;
        for (int i = 0; i < NBYTES; i++)
            scaled[i*8 +: 8] = scale_byte(pix_data[i*8 +: 8], bright);
    end

    assign busy      = (state != IDLE);
    assign pix_ready = busy && !buf_full && (requested < NUM_C);
    assign xfer      = pix_valid && pix_ready;
    assign accept    = (state == IDLE) && start;
    assign sent_inc  = sent + CW'(1);

    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        bit_cnt_nx   = bit_cnt;
        shift_nx     = shift;
        sent_nx      = sent;
        load_buf     = 1'b0;
        done_nx      = 1'b0;
        underrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FETCH;
                    sent_nx  = '0;
                end
            end
            FETCH: begin
                if (buf_full) begin
                    load_buf   = 1'b1;
                    shift_nx   = pix_buf;
                    bit_cnt_nx = '0;
                    timer_nx   = pix_buf[MSB] ? T1H_L : T0H_L;
                    state_nx   = HIGH;
                end
            end
            HIGH: begin
                if (timer == '0) begin
                    timer_nx = shift[MSB] ? T1L_L : T0L_L;
                    state_nx = LOW;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            LOW: begin
                if (timer != '0) begin
                    timer_nx = timer - TW'(1);
                end else if (bit_cnt != LAST_BIT) begin
                    shift_nx   = shift << 1;
                    bit_cnt_nx = bit_cnt + BW'(1);
                    timer_nx   = shift[MSB-1] ? T1H_L : T0H_L;
                    state_nx   = HIGH;
                end else begin
                    sent_nx = sent_inc;
                    if (sent_inc == NUM_C) begin
                        timer_nx = RES_L;
                        state_nx = LATCH;
                    end else if (buf_full) begin
                        // Back-to-back pixel: no extra low time on the line
                        load_buf   = 1'b1;
                        shift_nx   = pix_buf;
                        bit_cnt_nx = '0;
                        timer_nx   = pix_buf[MSB] ? T1H_L : T0H_L;
                        state_nx   = HIGH;
                    end else begin
                        underrun_set = 1'b1;
                        state_nx     = FETCH;
                    end
                end
            end
            LATCH: begin
                if (timer == '0) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            sent       <= '0;
            requested  <= '0;
            pix_buf    <= '0;
            buf_full   <= 1'b0;
            bright     <= '0;
            led_data   <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            bit_cnt    <= bit_cnt_nx;
            shift      <= shift_nx;
            sent       <= sent_nx;
            frame_done <= done_nx;
            led_data   <= (state_nx == HIGH);
            if (accept) begin
                bright    <= brightness;
                underrun  <= 1'b0;
                requested <= '0;
                buf_full  <= 1'b0;
            end else begin
                if (underrun_set)
                    underrun <= 1'b1;
                if (xfer) begin
                    pix_buf   <= scaled;
                    buf_full  <= 1'b1;
                    requested <= requested + CW'(1);
                end else if (load_buf) begin
                    buf_full <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ws2812_stream_driver.sv
// tb/tb_ws2812_stream_driver.sv - scoreboard bench decoding the NRZ line into per-bit pulse widths
module tb_ws2812_stream_driver;
    localparam int A0H = 35, A0L = 80, A1H = 70, A1L = 60, ARES = 6000;
    localparam int F0H = 3, F0L = 8, F1H = 7, F1L = 5, FRES = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_bc;
    int          sel;
    logic        st_start, st_valid;
    logic [7:0]  st_bright;
    logic [31:0] st_data;

    logic a_ready, a_led, a_busy, a_done, a_urun;
    logic b_ready, b_led, b_busy, b_done, b_urun;
    logic c_ready, c_led, c_busy, c_done, c_urun;

    ws2812_stream_driver #(.NUM_LED(1), .BITS_PER_LED(24), .T0H(A0H), .T0L(A0L),
                           .T1H(A1H), .T1L(A1L), .RES(ARES)) dut_a (
        .clk(clk), .reset_n(rst_a), .start(st_start && sel == 0), .brightness(st_bright),
        .pix_data(st_data[23:0]), .pix_valid(st_valid && sel == 0), .pix_ready(a_ready),
        .led_data(a_led), .busy(a_busy), .frame_done(a_done), .underrun(a_urun));

    ws2812_stream_driver #(.NUM_LED(8), .BITS_PER_LED(24), .T0H(F0H), .T0L(F0L),
                           .T1H(F1H), .T1L(F1L), .RES(FRES)) dut_b (
        .clk(clk), .reset_n(rst_bc), .start(st_start && sel == 1), .brightness(st_bright),
        .pix_data(st_data[23:0]), .pix_valid(st_valid && sel == 1), .pix_ready(b_ready),
        .led_data(b_led), .busy(b_busy), .frame_done(b_done), .underrun(b_urun));

    ws2812_stream_driver #(.NUM_LED(2), .BITS_PER_LED(32), .T0H(F0H), .T0L(F0L),
                           .T1H(F1H), .T1L(F1L), .RES(FRES)) dut_c (
        .clk(clk), .reset_n(rst_bc), .start(st_start && sel == 2), .brightness(st_bright),
        .pix_data(st_data), .pix_valid(st_valid && sel == 2), .pix_ready(c_ready),
        .led_data(c_led), .busy(c_busy), .frame_done(c_done), .underrun(c_urun));

    logic mon_led, mon_done, mon_ready, mon_busy, mon_urun, mon_rst;
    assign mon_led   = (sel == 0) ? a_led   : (sel == 1) ? b_led   : c_led;
    assign mon_done  = (sel == 0) ? a_done  : (sel == 1) ? b_done  : c_done;
    assign mon_ready = (sel == 0) ? a_ready : (sel == 1) ? b_ready : c_ready;
    assign mon_busy  = (sel == 0) ? a_busy  : (sel == 1) ? b_busy  : c_busy;
    assign mon_urun  = (sel == 0) ? a_urun  : (sel == 1) ? b_urun  : c_urun;
    assign mon_rst   = (sel == 0) ? rst_a   : rst_bc;

    typedef struct {
        int hi;
        int lo_min;
        int lo_max;
    } bit_rec_t;
    bit_rec_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int t_hi(input logic b);
        if (sel == 0) return b ? A1H : A0H;
        return b ? F1H : F0H;
    endfunction

    function automatic int t_lo(input logic b);
        if (sel == 0) return b ? A1L : A0L;
        return b ? F1L : F0L;
    endfunction

    // Push one expected pulse record per bit; the last bit's low absorbs latch time and gaps
    task automatic exp_pixel(input logic [31:0] px, input int nbits, input int gap_min,
                             input int gap_max, input bit last);
        for (int i = nbits - 1; i >= 0; i--) begin
            bit_rec_t r;
            r.hi     = t_hi(px[i]);
            r.lo_min = t_lo(px[i]);
            r.lo_max = r.lo_min;
            if (i == 0) begin
                if (last) begin
                    r.lo_min += (sel == 0) ? ARES : FRES;
                    r.lo_max += (sel == 0) ? ARES : FRES;
                end
                r.lo_min += gap_min;
                r.lo_max += gap_max;
            end
            exp_q.push_back(r);
        end
    endtask

    always @(posedge clk) begin
        if (st_valid && mon_ready)
            xfer_cnt++;
    end

    bit_rec_t cur;
    bit have_cur = 1'b0;
    bit prev = 1'b0;
    bit in_lo = 1'b0;
    int cnt = 0;

    always @(negedge clk) begin
        if (mon_done)
            done_cnt++;
        if (!mon_rst) begin
            exp_q.delete();
            have_cur = 1'b0;
            prev     = 1'b0;
            in_lo    = 1'b0;
            cnt      = 0;
        end else begin
            if (mon_led && !prev) begin
                if (in_lo)
                    check_rng("bit_low", cnt, cur.lo_min, cur.lo_max);
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                end
                in_lo = 1'b0;
                cnt   = 1;
            end else if (!mon_led && prev) begin
                if (have_cur)
                    check("bit_high", cnt, cur.hi);
                in_lo = have_cur;
                cnt   = 1;
            end else if (in_lo && mon_done) begin
                check_rng("bit_low_latch", cnt, cur.lo_min, cur.lo_max);
                in_lo = 1'b0;
            end else begin
                cnt++;
            end
            prev = mon_led;
        end
    end

    task automatic push(input logic [31:0] px);
        int n;
        n = 0;
        st_data  = px;
        st_valid = 1'b1;
        while (!mon_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!mon_ready)
            check("pix_ready_timeout", 0, 1);
        else
            @(negedge clk);
    endtask

    task automatic start_frame(input logic [7:0] b, input logic [31:0] px);
        st_bright = b;
        st_data   = px;
        st_valid  = 1'b1;
        st_start  = 1'b1;
        @(negedge clk);
        st_start = 1'b0;
        check("busy_after_start", int'(mon_busy), 1);
        push(px);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!mon_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_seen", int'(mon_done), 1);
        check("busy_at_done", int'(mon_busy), 0);
        @(negedge clk);
        check("frame_done_width", int'(mon_done), 0);
        check("expected_bits_left", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n, xb, db;
        sel = 0; rst_a = 1'b0; rst_bc = 1'b0;
        st_start = 1'b0; st_valid = 1'b0; st_bright = 8'd0; st_data = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_led", int'(a_led), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_ready", int'(a_ready), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_underrun", int'(a_urun), 0);
        rst_a = 1'b1; rst_bc = 1'b1;
        @(negedge clk);

        exp_pixel(32'hA50000, 24, 0, 0, 1'b1);
        start_frame(8'd255, 32'hA50000);
        st_valid = 1'b0;
        wait_done(20000);

        exp_pixel(32'h804000, 24, 0, 0, 1'b1);
        start_frame(8'd128, 32'hFF8001);
        st_valid = 1'b0;
        wait_done(20000);

        exp_pixel(32'h000000, 24, 0, 0, 1'b1);
        start_frame(8'd0, 32'h123456);
        st_valid = 1'b0;
        wait_done(20000);

        exp_pixel(32'hF0F0F0, 24, 0, 0, 1'b1);
        start_frame(8'd255, 32'hF0F0F0);
        st_valid = 1'b0;
        n = 0;
        while (!a_led && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("led_high_before_reset", int'(a_led), 1);
        #2 rst_a = 1'b0;
        #1;
        check("midbit_rst_led", int'(a_led), 0);
        check("midbit_rst_busy", int'(a_busy), 0);
        check("midbit_rst_ready", int'(a_ready), 0);
        check("midbit_rst_done", int'(a_done), 0);
        check("midbit_rst_underrun", int'(a_urun), 0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);

        exp_pixel(32'h00FF00, 24, 0, 0, 1'b1);
        start_frame(8'd255, 32'h00FF00);
        st_valid = 1'b0;
        wait_done(20000);

        sel = 1;
        @(negedge clk);
        xb = xfer_cnt; db = done_cnt;
        for (int i = 0; i < 8; i++)
            exp_pixel(32'h102030 + i * 32'h010101, 24, 0, 0, i == 7);
        start_frame(8'd255, 32'h102030);
        for (int i = 1; i < 8; i++)
            push(32'h102030 + i * 32'h010101);
        check("ready_after_last_pixel", int'(mon_ready), 0);
        st_valid = 1'b0;
        st_start = 1'b1;
        @(negedge clk);
        st_start = 1'b0;
        wait_done(10000);
        check("transfers_gapless", xfer_cnt - xb, 8);
        check("frames_gapless", done_cnt - db, 1);
        check("underrun_gapless", int'(mon_urun), 0);

        xb = xfer_cnt;
        exp_pixel(32'h0F0F0F, 24, 200, 205, 1'b0);
        for (int i = 1; i < 8; i++)
            exp_pixel(32'h0F0F0F + i, 24, 0, 0, i == 7);
        start_frame(8'd255, 32'h0F0F0F);
        st_valid = 1'b0;
        n = 0;
        while (!mon_urun && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("underrun_set", int'(mon_urun), 1);
        repeat (200) @(negedge clk);
        for (int i = 1; i < 8; i++)
            push(32'h0F0F0F + i);
        st_valid = 1'b0;
        wait_done(10000);
        check("underrun_sticky", int'(mon_urun), 1);
        check("transfers_underrun", xfer_cnt - xb, 8);

        for (int i = 0; i < 8; i++)
            exp_pixel(32'h5A5A5A ^ (i * 32'h111111), 24, 0, 0, i == 7);
        start_frame(8'd255, 32'h5A5A5A);
        check("underrun_cleared", int'(mon_urun), 0);
        for (int i = 1; i < 8; i++)
            push(32'h5A5A5A ^ (i * 32'h111111));
        st_valid = 1'b0;
        wait_done(10000);
        check("underrun_clean_frame", int'(mon_urun), 0);

        sel = 2;
        @(negedge clk);
        exp_pixel(32'h000000FF, 32, 0, 0, 1'b0);
        exp_pixel(32'h000000FF, 32, 0, 0, 1'b1);
        start_frame(8'd255, 32'h000000FF);
        push(32'h000000FF);
        st_valid = 1'b0;
        wait_done(10000);

        exp_pixel(32'h20401032, 32, 0, 0, 1'b0);
        exp_pixel(32'h00000001, 32, 0, 0, 1'b1);
        start_frame(8'd64, 32'h80FF40C8);
        push(32'h01020304);
        st_valid = 1'b0;
        wait_done(10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ws2812_stream_driver.md
# ws2812_stream_driver

Parametrised WS2812/SK6812 serial LED driver that streams pixels over a valid/ready interface instead of taking a whole-frame bus. Generates NRZ bit timing from cycle-count parameters, supports 24-bit (GRB) or 32-bit (GRBW) pixels, applies a global brightness scale, and reports busy, frame completion and underrun. Sits between the pixel source (UART/button logic or frame buffer) and the LED strip pin.

## Interface
- NUM_LED, 8: pixels per frame (1..1023)
- BITS_PER_LED, 24: bits per pixel; 24 or 32 only, a multiple of 8
- T0H, 35: '0' high time, cycles
- T0L, 80: '0' low time, cycles
- T1H, 70: '1' high time, cycles
- T1L, 60: '1' low time, cycles
- RES, 6000: latch/reset low time after the last bit, cycles
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  frame request; sampled only in IDLE
- brightness  in  8  global scale; sampled on an accepted start
- pix_data  in  BITS_PER_LED  pixel, MSB sent first, byte order as it goes on the wire
- pix_valid  in  1  pix_data is valid
- pix_ready  out  1  driver accepts a pixel this cycle
- led_data  out  1  serial line to the strip
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at the end of the frame
- underrun  out  1  sticky: the pixel buffer was empty when the next pixel was needed

## Operation
- Reset (async, reset_n=0): all outputs 0, state IDLE, buffer empty, counters 0.
- States: IDLE, FETCH, HIGH, LOW, LATCH.
- IDLE: start=1 → FETCH, busy=1, latch the brightness, clear underrun, requested=0, sent=0. start in any other state is ignored.
- One-entry pixel buffer. pix_ready=1 iff busy, the buffer is empty and requested<NUM_LED. A transfer occurs on pix_valid&&pix_ready.
- On each transfer, every byte b of pix_data is stored as (b*(brightness+1))>>8. This uses a 16-bit product and keeps the upper 8 bits. brightness=255 passes b unchanged; brightness=0 gives 0.
- FETCH: when the buffer is full, load the shift register from it, empty the buffer, bit_cnt=0, → HIGH.
- HIGH: led_data=1 for T1H cycles (MSB=1) or T0H cycles (MSB=0), then → LOW.
- LOW: led_data=0 for T1L or T0L cycles. At the end of LOW:
  - If bit_cnt<BITS_PER_LED-1: shift left, bit_cnt+1, → HIGH.
  - Else, pixel complete, sent+1:
    - If sent==NUM_LED → LATCH.
    - If the buffer is full → load it, → HIGH. No gap between pixels.
    - If the buffer is empty → set underrun, → FETCH with led_data=0, and resume when a pixel arrives.
- LATCH: led_data=0 for RES cycles, then frame_done=1 for one cycle, busy=0, → IDLE.
- The timer is sized to $clog2(max(RES,T0L,T1L,T0H,T1H)+1) bits. The pixel counters are sized to $clog2(NUM_LED+1) bits.
- A second start arriving while busy is dropped, not queued.

## Timing
- start accepted at edge k → busy=1 and pix_ready=1 after edge k. A first pixel already valid is accepted at edge k+1.
- Pixel accepted at edge j with the state in FETCH → led_data rises after edge j+1.
- Each bit lasts exactly THx+TxL cycles. Each pixel lasts the sum of its bit times.
- With pix_valid held high, the frame is gap-free. Frame length from the first led_data rise to frame_done = sum of bit times + RES, and frame_done is asserted in the cycle after LATCH ends.
- The buffer refills while the current pixel shifts. The source has a full pixel time to supply the next pixel before an underrun occurs.
- In an underrun, the low time on the line stretches. If the stretch exceeds about RES, the strip latches early. Flagging this is the only required behaviour.
- reset_n low mid-bit: led_data=0 immediately (async). The frame is abandoned, and busy/pix_ready=0.
- pix_data and pix_valid are ignored while pix_ready=0.

## Test plan
- NUM_LED=1, brightness=255, pixel 0xA50000 presented at start: bit highs are 70,35,70,35,35,70,35,70 followed by 16×35. Each bit period is 130 (T1) or 115 (T0). Then 6000 low cycles, frame_done for 1 cycle, busy falls.
- NUM_LED=8, pix_valid held high, incrementing pixels: exactly 8 transfers, no extra low time between pixels, underrun=0, pix_ready=0 after the 8th transfer.
- brightness=128, pixel 0xFF8001: the transmitted pattern equals 0x804000. brightness=0: all 24 highs are 35 cycles.
- Second pixel withheld for 200 cycles after the first pixel completes: led_data low for 200 extra cycles, underrun=1 and sticky, transmission resumes correctly, underrun cleared by the next start.
- start pulsed mid-frame: ignored, frame count unchanged. reset_n pulsed low mid-HIGH: led_data=0 in the same cycle, all outputs 0, next start runs a clean frame.
- BITS_PER_LED=32, pixel 0x000000FF: 24 T0 bits then 8 T1 bits per pixel, and the brightness scale is applied to all 4 bytes.
